// File: rtl/dlldel_adj_multi.sv
// dlldel_adj_multi: NCH independent delay-code trimmers sharing one DLL code.
// Each channel has a signed offset that is stepped +/-1 on a move rising edge.
// After a step, the channel stays busy for SETTLE cycles.
// The output code is dcntl plus the offset, clamped to the code range.
// Optional build macro: DLLDEL_ADJ_STICKY_CFLAG_EN makes the step-saturation
// flag sticky until load_n or reset.
module dlldel_adj_multi #(
  parameter int NCH    = 4,
  parameter int CODE_W = 9,
  parameter int ADJ_W  = 8,
  parameter int SETTLE = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CODE_W-1:0]     dcntl,
  input  logic [NCH-1:0]        load_n,
  input  logic [NCH-1:0]        move,
  input  logic [NCH-1:0]        dir,
  output logic [NCH-1:0]        ready,
  output logic [NCH*CODE_W-1:0] code_out,
  output logic [NCH-1:0]        cflag
);

  typedef enum logic {S_IDLE, S_SETTLE} state_t;

  // The sum must hold the full unsigned code, the full signed offset, and a sign bit.
  localparam int SW = ((CODE_W + 1 > ADJ_W) ? CODE_W + 1 : ADJ_W) + 1;
  localparam logic signed [ADJ_W-1:0] OFS_MAX = {1'b0, {(ADJ_W-1){1'b1}}};
  localparam logic signed [ADJ_W-1:0] OFS_MIN = {1'b1, {(ADJ_W-1){1'b0}}};
  localparam logic signed [SW-1:0]    SUM_MAX = SW'({CODE_W{1'b1}});
  localparam logic [7:0]              CNT_INIT = 8'(SETTLE - 1);

  logic [CODE_W-1:0]       dcntl_q;
  logic [NCH-1:0]          move_q;
  logic [NCH-1:0]          sat_q;
  logic [NCH-1:0]          cflag_q;
  logic [NCH-1:0]          clamp_nxt;
  state_t                  state    [NCH];
  logic [7:0]              cnt      [NCH];
  logic signed [ADJ_W-1:0] offset   [NCH];
  logic [CODE_W-1:0]       code_q   [NCH];
  logic [CODE_W-1:0]       code_nxt [NCH];
  logic signed [SW-1:0]    sum      [NCH];

  // Per-channel adjusted code: dcntl_q + offset, clamped to [0, 2^CODE_W-1]
  always_comb begin
    clamp_nxt = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      sum[i]      = $signed({{(SW-CODE_W){1'b0}}, dcntl_q}) + SW'(offset[i]);
      code_nxt[i] = sum[i][CODE_W-1:0];
      if (sum[i] < 0) begin
        code_nxt[i]  = '0;
        clamp_nxt[i] = 1'b1;
      end else if (sum[i] > SUM_MAX) begin
        code_nxt[i]  = '1;
        clamp_nxt[i] = 1'b1;
      end
    end
  end

  // Pack per-channel state into the output ports
  always_comb begin
    ready    = '0;
    code_out = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      ready[i]                        = (state[i] == S_IDLE);
      code_out[i*CODE_W +: CODE_W]    = code_q[i];
    end
  end

  assign cflag = cflag_q;

  // Input pipeline, step FSMs, offsets and registered outputs for every channel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dcntl_q <= '0;
      move_q  <= '0;
      sat_q   <= '0;
      cflag_q <= '0;
      for (int unsigned i = 0; i < NCH; i++) begin
        state[i]  <= S_IDLE;
        cnt[i]    <= '0;
        offset[i] <= '0;
        code_q[i] <= '0;
      end
    end else begin
      dcntl_q <= dcntl;
      for (int unsigned i = 0; i < NCH; i++) begin
        move_q[i]  <= move[i];
        code_q[i]  <= code_nxt[i];
        cflag_q[i] <= sat_q[i] | clamp_nxt[i];
        if (!load_n[i]) begin
          offset[i] <= '0;
          state[i]  <= S_IDLE;
          cnt[i]    <= '0;
          sat_q[i]  <= 1'b0;
        end else begin
          case (state[i])
            S_IDLE: begin
              if (move[i] && !move_q[i]) begin
                state[i] <= S_SETTLE;
                cnt[i]   <= CNT_INIT;
                if ((!dir[i] && offset[i] == OFS_MAX) ||
                    ( dir[i] && offset[i] == OFS_MIN)) begin
                  sat_q[i] <= 1'b1;
                end else begin
                  offset[i] <= dir[i] ? offset[i] - ADJ_W'(1) : offset[i] + ADJ_W'(1);
`ifdef DLLDEL_ADJ_STICKY_CFLAG_EN
                  sat_q[i] <= sat_q[i];
`else
                  sat_q[i] <= 1'b0;
`endif
                end
              end
            end
            S_SETTLE: begin
              if (cnt[i] == 8'd0) state[i] <= S_IDLE;
              else                cnt[i]   <= cnt[i] - 8'd1;
            end
            default: state[i] <= S_IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_dlldel_adj_multi.sv
// Bench for dlldel_adj_multi (NCH=4, CODE_W=9, ADJ_W=8, SETTLE=4).
// The bench uses a vector table, hand-written corner sequences, and random
// stimulus checked against an integer reference model.
module tb_dlldel_adj_multi;

  localparam int NCH    = 4;
  localparam int CODE_W = 9;
  localparam int ADJ_W  = 8;
  localparam int SETTLE = 4;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [CODE_W-1:0]     dcntl;
  logic [NCH-1:0]        load_n, move, dir;
  logic [NCH-1:0]        ready, cflag;
  logic [NCH*CODE_W-1:0] code_out;

  int n_chk  = 0;
  int n_fail = 0;

  dlldel_adj_multi #(.NCH(NCH), .CODE_W(CODE_W), .ADJ_W(ADJ_W), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n), .dcntl(dcntl), .load_n(load_n), .move(move),
    .dir(dir), .ready(ready), .code_out(code_out), .cflag(cflag)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // Reference model: integer offset, busy cycles left, saturation flag
  int m_off[NCH], m_busy[NCH], m_code[NCH], m_dq;
  bit m_sat[NCH], m_mq[NCH], m_cf[NCH];

  task automatic model_reset();
    m_dq = 0;
    for (int i = 0; i < NCH; i++) begin
      m_off[i] = 0; m_busy[i] = 0; m_code[i] = 0;
      m_sat[i] = 0; m_mq[i] = 0; m_cf[i] = 0;
    end
  endtask

  task automatic model_clock();
    int s;
    int tgt;
    for (int i = 0; i < NCH; i++) begin
      s = m_dq + m_off[i];
      m_code[i] = (s < 0) ? 0 : (s > 511) ? 511 : s;
      m_cf[i]   = m_sat[i] | (s < 0) | (s > 511);
    end
    m_dq = int'(dcntl);
    for (int i = 0; i < NCH; i++) begin
      bit edge_seen;
      edge_seen = move[i] && !m_mq[i];
      m_mq[i] = move[i];
      if (!load_n[i]) begin
        m_off[i] = 0; m_busy[i] = 0; m_sat[i] = 0;
      end else if (m_busy[i] > 0) begin
        m_busy[i]--;
      end else if (edge_seen) begin
        m_busy[i] = SETTLE;
        tgt = m_off[i] + (dir[i] ? -1 : 1);
        if (tgt < -128 || tgt > 127) m_sat[i] = 1;
        else begin
          m_off[i] = tgt;
`ifndef DLLDEL_ADJ_STICKY_CFLAG_EN
          m_sat[i] = 0;
`endif
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int code_of(input int ch);
    return int'(code_out[ch*CODE_W +: CODE_W]);
  endfunction

  task automatic reset_checked();
    rst_n = 1'b0;
    #1;
    chk("rst_ready", int'(ready), 15);
    chk("rst_code",  int'(code_out == '0), 1);
    chk("rst_cflag", int'(cflag), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  // Pulse move on one channel, then count cycles with ready low (bounded)
  task automatic do_step(input int ch, input bit d, output int lowcnt);
    dir[ch]  = d;
    move[ch] = 1'b1;
    tick();
    move[ch] = 1'b0;
    lowcnt = 0;
    while (!ready[ch] && lowcnt < 50) begin
      lowcnt++;
      tick();
    end
  endtask

  typedef struct {
    int dcntl;
    int ch;
    bit step;
    bit d;
    int exp_code;
    bit exp_cf;
  } vec_t;

  vec_t tbl[12];

  initial begin
    int lc;
    dcntl = '0; load_n = '1; move = '0; dir = '0;
    model_reset();
    tbl[0]  = '{100, 0, 1, 0, 101, 0};
    tbl[1]  = '{100, 0, 1, 0, 102, 0};
    tbl[2]  = '{100, 0, 1, 0, 103, 0};
    tbl[3]  = '{510, 3, 1, 0, 511, 0};
    tbl[4]  = '{510, 3, 1, 0, 511, 1};
    tbl[5]  = '{510, 3, 1, 0, 511, 1};
    tbl[6]  = '{510, 3, 1, 0, 511, 1};
    tbl[7]  = '{510, 3, 1, 0, 511, 1};
    tbl[8]  = '{400, 3, 0, 0, 405, 0};
    tbl[9]  = '{400, 0, 0, 0, 403, 0};
    tbl[10] = '{0,   1, 1, 1, 0,   1};
    tbl[11] = '{5,   1, 0, 0, 4,   0};

    reset_checked();

    for (int r = 0; r < 12; r++) begin
      dcntl = CODE_W'(tbl[r].dcntl);
      if (tbl[r].step) begin
        do_step(tbl[r].ch, tbl[r].d, lc);
        chk("tbl_ready_low_cycles", lc, SETTLE);
      end
      tick(); tick(); tick();
      chk("tbl_code",  code_of(tbl[r].ch), tbl[r].exp_code);
      chk("tbl_cflag", int'(cflag[tbl[r].ch]), int'(tbl[r].exp_cf));
      if (r == 2) begin
        for (int c = 1; c < NCH; c++) chk("tbl_other_ch", code_of(c), 100);
      end
    end

    // Second edge during SETTLE is dropped
    dcntl = 9'd200;
    load_n[1] = 1'b0; tick(); load_n[1] = 1'b1;
    move[1] = 1'b1; dir[1] = 1'b0; tick();
    move[1] = 1'b0; tick();
    move[1] = 1'b1; tick();
    chk("drop_ready_low", int'(ready[1]), 0);
    move[1] = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    chk("drop_code", code_of(1), 201);
    chk("drop_ready", int'(ready[1]), 1);

    // load_n has priority over a simultaneous move edge
    load_n[0] = 1'b0; move[0] = 1'b1; dir[0] = 1'b0; tick();
    load_n[0] = 1'b1; move[0] = 1'b0;
    chk("load_ready", int'(ready[0]), 1);
    tick(); tick();
    chk("load_code", code_of(0), 200);

    // Offset saturation at the negative limit
    dcntl = 9'd300;
    load_n[2] = 1'b0; tick(); load_n[2] = 1'b1;
    for (int k = 0; k < 128; k++) do_step(2, 1'b1, lc);
    tick(); tick();
    chk("sat_code_m128", code_of(2), 172);
    chk("sat_cflag_pre", int'(cflag[2]), 0);
    do_step(2, 1'b1, lc);
    chk("sat_step_busy", lc, SETTLE);
    tick(); tick();
    chk("sat_code_hold", code_of(2), 172);
    chk("sat_cflag_set", int'(cflag[2]), 1);
    do_step(2, 1'b0, lc);
    tick(); tick();
    chk("sat_code_m127", code_of(2), 173);
`ifdef DLLDEL_ADJ_STICKY_CFLAG_EN
    chk("sat_cflag_after", int'(cflag[2]), 1);
`else
    chk("sat_cflag_after", int'(cflag[2]), 0);
`endif

    // Random traffic against the reference model
    for (int k = 0; k < 400; k++) begin
      dcntl = CODE_W'($urandom_range(0, 511));
      for (int c = 0; c < NCH; c++) begin
        move[c]   = $urandom_range(0, 1) == 1;
        dir[c]    = $urandom_range(0, 1) == 1;
        load_n[c] = $urandom_range(0, 15) != 0;
      end
      tick();
      for (int c = 0; c < NCH; c++) begin
        chk("rand_ready", int'(ready[c]), int'(m_busy[c] == 0));
        chk("rand_code",  code_of(c), m_code[c]);
        chk("rand_cflag", int'(cflag[c]), int'(m_cf[c]));
      end
    end
    move = '0; load_n = '1;

    // Reset in the middle of SETTLE
    dcntl = 9'd50;
    do_step(0, 1'b0, lc);
    move[0] = 1'b1; tick(); move[0] = 1'b0; tick();
    chk("mid_busy", int'(ready[0]), 0);
    reset_checked();
    tick(); tick();
    chk("post_rst_ready", int'(ready), 15);
    for (int c = 0; c < NCH; c++) chk("post_rst_code", code_of(c), 50);

    // A move held high through reset counts as a rising edge
    move[1] = 1'b1;
    reset_checked();
    tick();
    chk("held_move_edge", int'(ready[1]), 0);
    move[1] = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    chk("held_move_code", code_of(1), 51);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
